// File: rtl/eth_phy_10g_link_ctrl_pkg.sv
// Shared definitions for the 10G BASE-R lane link controller: state codes,
// counter widths and saturation limits.
package eth_phy_10g_link_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERDES_RST = 3'd1,
        ST_WAIT_LOCK  = 3'd2,
        ST_STABLE     = 3'd3,
        ST_UP         = 3'd4,
        ST_PRBS       = 3'd5
    } state_t;

    localparam int ERR_CNT_W  = 7;
    localparam int PRBS_CNT_W = 32;
    localparam int EVT_CNT_W  = 16;

    localparam logic [PRBS_CNT_W-1:0] PRBS_CNT_MAX = '1;
    localparam logic [EVT_CNT_W-1:0]  EVT_CNT_MAX  = '1;

    // States that belong to the normal bring-up sequence (not IDLE, not PRBS).
    function automatic logic is_link_seq(state_t s);
        return (s == ST_SERDES_RST) || (s == ST_WAIT_LOCK) ||
               (s == ST_STABLE) || (s == ST_UP);
    endfunction

endpackage

// File: rtl/eth_sat_counter.sv
// Saturating accumulator: adds inc when en is high, clears synchronously on clr
// (clear wins over an add), async active-low reset.
module eth_sat_counter #(
    parameter int           W       = 16,
    parameter int           INC_W   = 1,
    parameter logic [W-1:0] SAT_MAX = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     count
);

    logic [W:0] sum;

    // One extra bit keeps the carry so the overflow compare is exact.
    always_comb begin
        sum = {1'b0, count} + {{(W + 1 - INC_W){1'b0}}, inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (sum > {1'b0, SAT_MAX}) begin
                count <= SAT_MAX;
            end else begin
                count <= sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/eth_phy_10g_link_ctrl.sv
// Link supervisor for one 10G BASE-R lane: SERDES reset sequencing, lock
// debounce, timeout retry and PRBS31 test mode. Event statistics are built only
// when ETH_PHY_10G_LINK_CTRL_STATS_EN is defined; otherwise they read as zero.
module eth_phy_10g_link_ctrl
    import eth_phy_10g_link_ctrl_pkg::*;
#(
    parameter int LOCK_TIMEOUT       = 1562500,
    parameter int STABLE_CYCLES      = 19531,
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int TIMER_WIDTH        = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_enable,
    input  logic                  cfg_prbs_mode,
    input  logic                  cfg_err_clear,
    input  logic                  rx_block_lock,
    input  logic                  rx_high_ber,
    input  logic [ERR_CNT_W-1:0]  rx_error_count,
    input  logic                  phy_rx_reset_req,
    output logic                  serdes_rx_reset,
    output logic                  tx_prbs31_enable,
    output logic                  rx_prbs31_enable,
    output logic                  link_up,
    output logic [2:0]            state,
    output logic [PRBS_CNT_W-1:0] prbs_err_count,
    output logic [EVT_CNT_W-1:0]  link_down_count,
    output logic [EVT_CNT_W-1:0]  reset_retry_count
);

    localparam logic [TIMER_WIDTH-1:0] RST_LAST    = TIMER_WIDTH'(RESET_PULSE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] LOCK_LAST   = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] STABLE_LAST = TIMER_WIDTH'(STABLE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMER_ONE   = TIMER_WIDTH'(1);

    state_t                 state_q;
    state_t                 state_d;
    logic [TIMER_WIDTH-1:0] timer_q;
    logic [TIMER_WIDTH-1:0] timer_d;
    logic                   lock_good;
    logic                   mode_mismatch;
    logic                   reset_req_hit;
    logic                   prbs_acc_en;

    assign lock_good     = rx_block_lock && !rx_high_ber;
    assign mode_mismatch = (cfg_prbs_mode && is_link_seq(state_q)) ||
                           (!cfg_prbs_mode && (state_q == ST_PRBS));
    assign reset_req_hit = phy_rx_reset_req &&
                           ((state_q == ST_WAIT_LOCK) || (state_q == ST_STABLE) ||
                            (state_q == ST_UP));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (!cfg_enable || mode_mismatch) begin
            state_d = ST_IDLE;
        end else if (reset_req_hit) begin
            state_d = ST_SERDES_RST;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = cfg_prbs_mode ? ST_PRBS : ST_SERDES_RST;
                end
                ST_SERDES_RST: begin
                    if (timer_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_good) begin
                        state_d = ST_STABLE;
                    end else if (timer_q == LOCK_LAST) begin
                        state_d = ST_SERDES_RST;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!lock_good) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = ST_UP;
                    end else begin
                        timer_d = timer_q + TIMER_ONE;
                    end
                end
                ST_UP: begin
                    if (!lock_good) begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_PRBS: begin
                    state_d = ST_PRBS;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        // Every state change restarts the timer; states without a bound hold it.
        if (state_d != state_q) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            timer_q          <= '0;
            serdes_rx_reset  <= 1'b0;
            tx_prbs31_enable <= 1'b0;
            rx_prbs31_enable <= 1'b0;
            link_up          <= 1'b0;
        end else begin
            state_q          <= state_d;
            timer_q          <= timer_d;
            serdes_rx_reset  <= (state_d == ST_SERDES_RST);
            tx_prbs31_enable <= (state_d == ST_PRBS);
            rx_prbs31_enable <= (state_d == ST_PRBS);
            link_up          <= (state_d == ST_UP);
        end
    end

    assign state = state_q;

    // The exit cycle out of PRBS is excluded from accumulation.
    assign prbs_acc_en = (state_q == ST_PRBS) && (state_d == ST_PRBS);

    eth_sat_counter #(
        .W       (PRBS_CNT_W),
        .INC_W   (ERR_CNT_W),
        .SAT_MAX (PRBS_CNT_MAX)
    ) u_prbs_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cfg_err_clear),
        .en    (prbs_acc_en),
        .inc   (rx_error_count),
        .count (prbs_err_count)
    );

`ifdef ETH_PHY_10G_LINK_CTRL_STATS_EN
    logic retry_evt;
    logic down_evt;

    // A WAIT_LOCK->SERDES_RST move without a PHY request can only be a timeout.
    assign retry_evt = (state_q == ST_WAIT_LOCK) && (state_d == ST_SERDES_RST) &&
                       !phy_rx_reset_req;
    assign down_evt  = (state_q == ST_UP) && (state_d == ST_WAIT_LOCK);

    eth_sat_counter #(
        .W       (EVT_CNT_W),
        .INC_W   (1),
        .SAT_MAX (EVT_CNT_MAX)
    ) u_down_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (down_evt),
        .inc   (1'b1),
        .count (link_down_count)
    );

    eth_sat_counter #(
        .W       (EVT_CNT_W),
        .INC_W   (1),
        .SAT_MAX (EVT_CNT_MAX)
    ) u_retry_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .en    (retry_evt),
        .inc   (1'b1),
        .count (reset_retry_count)
    );
`else
    assign link_down_count   = '0;
    assign reset_retry_count = '0;
`endif

endmodule

// File: tb/tb_eth_phy_10g_link_ctrl.sv
// Directed bench for eth_phy_10g_link_ctrl with short timer parameters.
module tb_eth_phy_10g_link_ctrl;

`ifdef ETH_PHY_10G_LINK_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_enable, cfg_prbs_mode, cfg_err_clear;
    logic        rx_block_lock, rx_high_ber, phy_rx_reset_req;
    logic [6:0]  rx_error_count;
    logic        serdes_rx_reset, tx_prbs31_enable, rx_prbs31_enable, link_up;
    logic [2:0]  state;
    logic [31:0] prbs_err_count;
    logic [15:0] link_down_count, reset_retry_count;

    logic        sat_clr, sat_en;
    logic [6:0]  sat_inc;
    logic [7:0]  sat_count;

    int tests  = 0;
    int failed = 0;
    int pulse_cnt;

    always #5 clk = ~clk;

    eth_phy_10g_link_ctrl #(
        .LOCK_TIMEOUT       (100),
        .STABLE_CYCLES      (20),
        .RESET_PULSE_CYCLES (4),
        .TIMER_WIDTH        (24)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cfg_enable        (cfg_enable),
        .cfg_prbs_mode     (cfg_prbs_mode),
        .cfg_err_clear     (cfg_err_clear),
        .rx_block_lock     (rx_block_lock),
        .rx_high_ber       (rx_high_ber),
        .rx_error_count    (rx_error_count),
        .phy_rx_reset_req  (phy_rx_reset_req),
        .serdes_rx_reset   (serdes_rx_reset),
        .tx_prbs31_enable  (tx_prbs31_enable),
        .rx_prbs31_enable  (rx_prbs31_enable),
        .link_up           (link_up),
        .state             (state),
        .prbs_err_count    (prbs_err_count),
        .link_down_count   (link_down_count),
        .reset_retry_count (reset_retry_count)
    );

    // Narrow instance of the saturating counter so the saturation edge is reachable.
    eth_sat_counter #(
        .W     (8),
        .INC_W (7)
    ) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sat_clr),
        .en    (sat_en),
        .inc   (sat_inc),
        .count (sat_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n            = 1'b0;
        cfg_enable       = 1'b0;
        cfg_prbs_mode    = 1'b0;
        cfg_err_clear    = 1'b0;
        rx_block_lock    = 1'b0;
        rx_high_ber      = 1'b0;
        rx_error_count   = '0;
        phy_rx_reset_req = 1'b0;
        sat_clr          = 1'b0;
        sat_en           = 1'b0;
        sat_inc          = '0;
        tick(2);
        check("rst_state", 32'(state), 32'd0);
        check("rst_serdes", 32'(serdes_rx_reset), 32'd0);
        check("rst_link_up", 32'(link_up), 32'd0);
        check("rst_prbs_en", 32'({tx_prbs31_enable, rx_prbs31_enable}), 32'd0);
        check("rst_prbs_cnt", prbs_err_count, 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Bring-up: sample 0 is this point; enable takes effect at the next edge.
        cfg_enable = 1'b1;
        pulse_cnt  = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            pulse_cnt += int'(serdes_rx_reset);
        end
        check("pulse_width", 32'(pulse_cnt), 32'd4);
        check("wait_lock_state", 32'(state), 32'd2);
        tick(8);
        rx_block_lock = 1'b1;
        tick(1);
        check("stable_entry", 32'(state), 32'd3);
        tick(19);
        check("stable_last", 32'(state), 32'd3);
        check("no_link_yet", 32'(link_up), 32'd0);
        tick(1);
        check("up_state", 32'(state), 32'd4);
        check("link_up_rise", 32'(link_up), 32'd1);

        // Lock drop in UP.
        rx_block_lock = 1'b0;
        tick(1);
        check("drop_link_up", 32'(link_up), 32'd0);
        check("drop_state", 32'(state), 32'd2);
        check("link_down_1", 32'(link_down_count), STATS ? 32'd1 : 32'd0);

        // One-cycle glitch at STABLE timer 10.
        rx_block_lock = 1'b1;
        tick(1);
        check("restable", 32'(state), 32'd3);
        tick(10);
        rx_block_lock = 1'b0;
        tick(1);
        check("glitch_wait", 32'(state), 32'd2);
        rx_block_lock = 1'b1;
        tick(1);
        check("glitch_stable", 32'(state), 32'd3);
        tick(19);
        check("glitch_no_up", 32'(link_up), 32'd0);
        tick(1);
        check("glitch_up", 32'(state), 32'd4);
        check("glitch_no_count", 32'(link_down_count), STATS ? 32'd1 : 32'd0);

        // Disable beats a PHY reset request.
        phy_rx_reset_req = 1'b1;
        cfg_enable       = 1'b0;
        tick(1);
        check("prio_idle", 32'(state), 32'd0);
        check("prio_serdes", 32'(serdes_rx_reset), 32'd0);
        phy_rx_reset_req = 1'b0;
        cfg_enable       = 1'b1;
        tick(26);
        check("reup", 32'(state), 32'd4);

        // PHY reset request alone in UP.
        phy_rx_reset_req = 1'b1;
        tick(1);
        check("req_serdes_state", 32'(state), 32'd1);
        check("req_serdes_out", 32'(serdes_rx_reset), 32'd1);
        check("req_link_up", 32'(link_up), 32'd0);
        check("req_down_cnt", 32'(link_down_count), STATS ? 32'd1 : 32'd0);
        phy_rx_reset_req = 1'b0;

        // Lock never returns: retries every 104 cycles.
        rx_block_lock = 1'b0;
        tick(103);
        check("to_last_wait", 32'(state), 32'd2);
        check("retry_0", 32'(reset_retry_count), 32'd0);
        tick(1);
        check("to_retry_state", 32'(state), 32'd1);
        check("retry_1", 32'(reset_retry_count), STATS ? 32'd1 : 32'd0);
        tick(208);
        check("retry3_state", 32'(state), 32'd1);
        check("retry_3", 32'(reset_retry_count), STATS ? 32'd3 : 32'd0);

        // Async reset between edges while in SERDES_RST.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_serdes", 32'(serdes_rx_reset), 32'd0);
        check("async_state", 32'(state), 32'd0);
        check("async_retry", 32'(reset_retry_count), 32'd0);
        check("async_down", 32'(link_down_count), 32'd0);
        tick(1);

        // PRBS mode; link inputs must be ignored.
        cfg_prbs_mode    = 1'b1;
        rx_error_count   = 7'd5;
        phy_rx_reset_req = 1'b1;
        rx_high_ber      = 1'b1;
        rst_n            = 1'b1;
        tick(1);
        check("prbs_state", 32'(state), 32'd5);
        check("prbs_en", 32'({tx_prbs31_enable, rx_prbs31_enable}), 32'd3);
        check("prbs_entry_cnt", prbs_err_count, 32'd0);
        tick(10);
        check("prbs_50", prbs_err_count, 32'd50);
        check("prbs_hold_state", 32'(state), 32'd5);
        cfg_err_clear  = 1'b1;
        rx_error_count = 7'd7;
        tick(1);
        check("prbs_clear", prbs_err_count, 32'd0);
        cfg_err_clear  = 1'b0;
        rx_error_count = 7'd3;
        tick(2);
        check("prbs_6", prbs_err_count, 32'd6);
        cfg_prbs_mode = 1'b0;
        tick(1);
        check("prbs_exit_state", 32'(state), 32'd0);
        check("prbs_exit_cnt", prbs_err_count, 32'd6);
        check("prbs_exit_en", 32'({tx_prbs31_enable, rx_prbs31_enable}), 32'd0);
        phy_rx_reset_req = 1'b0;
        rx_high_ber      = 1'b0;
        tick(1);
        check("post_prbs_serdes", 32'(state), 32'd1);
        check("post_prbs_hold", prbs_err_count, 32'd6);
        cfg_prbs_mode = 1'b1;
        tick(1);
        check("mismatch_idle", 32'(state), 32'd0);
        tick(1);
        check("mismatch_prbs", 32'(state), 32'd5);

        // Saturation on the narrow counter: 127, 254, then stick at 255.
        sat_en  = 1'b1;
        sat_inc = 7'd127;
        tick(2);
        check("sat_254", 32'(sat_count), 32'd254);
        tick(1);
        check("sat_255", 32'(sat_count), 32'd255);
        tick(1);
        check("sat_stick", 32'(sat_count), 32'd255);
        sat_clr = 1'b1;
        tick(1);
        check("sat_clr", 32'(sat_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
